store_narrow: RTL and testbench
===============================

# store_narrow

Store-path narrowing unit for the data-memory interface: the write-side counterpart of the load sign/zero extension. It accepts a 32-bit register value plus a store size (byte, halfword, word) and an address. It narrows the value to the addressed lane(s) and commits it to a word-only data memory. Sub-word stores use a read-modify-write sequence. Sits between the CPU store datapath and the data memory.

## Interface
- ADDR_W, 32, byte-address width
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  byte address
- req_data  in  32  register value; low bits used for sub-word stores
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
- mem_rd_en  out  1  one-cycle read strobe
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid; latency ≥1 cycle, unbounded
- mem_wr_en  out  1  one-cycle write strobe
- mem_wdata  out  32  merged write word
- mem_be  out  4  byte enables, present only with STORE_BE_EN
- done  out  1  one-cycle pulse on completion (including error completion)
- misalign_err  out  1  one-cycle pulse, coincident with done, on a rejected request

## Operation
- Little-endian lanes: lane = addr[1:0]. Byte n occupies wdata[8n+7:8n].
- Byte store: req_data[7:0] replaces lane addr[1:0]. Halfword: req_data[15:0] replaces lanes {addr[1],0} and {addr[1],1}. Word: req_data written whole.
- Alignment check at accept: halfword requires addr[0]=0; word requires addr[1:0]=0; size 11 is always illegal. Illegal requests perform no memory access.
- Request, address, data and size are registered at accept. Inputs are ignored after accept.
- FSM states:
  - IDLE: req_ready=1. On req_valid:
    - illegal request → ERR
    - word request → WR
    - sub-word request → RD
  - RD: mem_rd_en=1 for exactly one cycle, then → WAIT.
  - WAIT: hold until mem_rvalid. Capture mem_rdata, merge, → WR.
  - WR: mem_wr_en=1 and done=1 for one cycle → IDLE.
  - ERR: done=1 and misalign_err=1 for one cycle → IDLE.
- req_ready=0 in every state except IDLE. There is no back-to-back acceptance in the WR or ERR cycles.
- mem_rvalid outside WAIT is ignored.
- Reset values: state IDLE; req_ready=1 (combinational from IDLE); mem_rd_en, mem_wr_en, done, misalign_err=0; mem_addr, mem_wdata=0.
- Reset asserted mid-sequence returns to IDLE immediately. A pending write is dropped. No partial write is possible because the write is a single strobe.

## Timing
- Accept at edge T (req_valid && req_ready).
- Word store: mem_wr_en/done high in cycle T+1.
- Sub-word store: mem_rd_en high in T+1. With read latency L (rvalid in T+1+L), mem_wr_en/done are high in T+2+L.
- Error: done/misalign_err high in T+1.
- mem_addr is stable from T+1 through the WR cycle.
- All outputs are registered or decoded from state only, with no combinational path from req_* to mem_*.

## Configuration
- STORE_BE_EN defined:
  - The mem_be port exists. Sub-word stores skip RD/WAIT and go straight to WR, with mem_be set to the addressed lanes (byte: one-hot of addr[1:0]; half: 0011 or 1100; word: 1111).
  - mem_wdata carries the narrowed value replicated across lanes.
  - Latency matches the word store.
- STORE_BE_EN undefined: no mem_be port; read-modify-write as described above.

## Structure
- Package store_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum (IDLE, RD, WAIT, WR, ERR), and the lane-mask function.
- Sub-module store_merge: combinational. Inputs are old word, new data, size and addr[1:0]. Outputs are the merged word and the byte mask. It is shared by the RMW path and the BE path.

## Test plan
- Word store: addr 0x10, data 0xDEADBEEF, size 10 → T+1 mem_wr_en, mem_addr 0x10, wdata 0xDEADBEEF, done; no mem_rd_en.
- Byte RMW: addr 0x23, data 0x000000AB, memory returns 0x11223344 after L=3 → one mem_rd_en at 0x20, then wdata 0xAB223344 at T+5, done.
- Halfword RMW: addr 0x06, data 0x0000CAFE, old 0x11223344 → wdata 0xCAFE3344.
- Misaligned: halfword at 0x05, then word at 0x0A, then size 11 → each gives done+misalign_err at T+1, no mem strobes.
- Reset during WAIT: assert rstn=0 before rvalid → no mem_wr_en ever, req_ready=1 after release; a stray late rvalid is ignored.
- STORE_BE_EN build: byte at 0x22, data 0x5A → T+1 mem_be 0100, wdata 0x5A5A5A5A, no read.

Source files
------------

// File: rtl/store_narrow_pkg.sv
// Shared encodings and lane helpers for the store-narrowing unit.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    ERR
  } state_e;

  // Byte lanes touched by a store of the given size at the given lane offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_legal = 1'b1;
      SZ_HALF: is_legal = ~lane[0];
      SZ_WORD: is_legal = (lane == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Narrowed value copied into every lane it could land in.
  function automatic logic [31:0] replicate(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_BYTE: replicate = {4{data[7:0]}};
      SZ_HALF: replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/store_narrow_if.sv
// CPU-store request and data-memory port bundle for store_narrow.
// mem_be exists only when STORE_BE_EN is defined.
interface store_narrow_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
`ifdef STORE_BE_EN
  logic [3:0]        mem_be;
`endif
  logic              done;
  logic              misalign_err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata, mem_rvalid,
    input  `ifdef STORE_BE_EN mem_be, `endif
           req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, misalign_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_rvalid,
    output `ifdef STORE_BE_EN mem_be, `endif
           req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, misalign_err
  );
endinterface

// File: rtl/store_narrow_merge.sv
// Lane merge: inserts the narrowed store value into an old word and reports
// which byte lanes it occupies.
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_word,
  output logic [3:0]  o_mask
);
  logic [31:0] w_rep;

  always_comb begin
    // NOTE: every output gets a full default before the loop so no latch is inferred.
    w_rep  = replicate(i_new, i_size);
    o_mask = lane_mask(i_size, i_lane);
    o_word = i_old;
    for (int i = 0; i < 4; i++) begin
      if (o_mask[i]) o_word[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_narrow.sv
// Store-path narrowing unit: sub-word stores by read-modify-write, or by byte
// enables when STORE_BE_EN is defined.
module store_narrow
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rstn,
  store_narrow_if.slave bus
);
  state_e            r_state;
  logic              r_rd_en, r_wr_en, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_idle, w_legal;
  logic [31:0]       w_m_old, w_m_new, w_word;
  logic [1:0]        w_m_size, w_m_lane;
  logic [3:0]        w_mask;

  assign w_idle  = (r_state == IDLE);
  assign w_legal = is_legal(bus.req_size, bus.req_addr[1:0]);

`ifdef STORE_BE_EN
  logic [3:0] r_be;
  // Old word = replicated value, so the merge yields the fully replicated word.
  assign w_m_old  = replicate(bus.req_data, bus.req_size);
  assign w_m_new  = bus.req_data;
  assign w_m_size = bus.req_size;
  assign w_m_lane = bus.req_addr[1:0];
  assign bus.mem_be = r_be;
`else
  logic [31:0] r_data;
  logic [1:0]  r_size, r_lane;
  // Live request feeds the merge at accept; the captured copy feeds it in WAIT.
  assign w_m_old  = w_idle ? 32'h0 : bus.mem_rdata;
  assign w_m_new  = w_idle ? bus.req_data : r_data;
  assign w_m_size = w_idle ? bus.req_size : r_size;
  assign w_m_lane = w_idle ? bus.req_addr[1:0] : r_lane;
`endif

  store_merge u_merge (
    .i_old  (w_m_old),
    .i_new  (w_m_new),
    .i_size (w_m_size),
    .i_lane (w_m_lane),
    .o_word (w_word),
    .o_mask (w_mask)
  );

  assign bus.req_ready    = w_idle;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_rd_en    = r_rd_en;
  assign bus.mem_wr_en    = r_wr_en;
  assign bus.mem_wdata    = r_wdata;
  assign bus.done         = r_done;
  assign bus.misalign_err = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
`ifdef STORE_BE_EN
      r_be    <= 4'h0;
`else
      r_data  <= 32'h0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
`endif
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (!w_legal) begin
              r_state <= ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
`ifdef STORE_BE_EN
            else begin
              r_state <= WR;
              r_wr_en <= 1'b1;
              r_done  <= 1'b1;
              r_wdata <= w_word;
              r_be    <= w_mask;
            end
`else
            else if (w_mask == 4'hF) begin
              r_state <= WR;
              r_wr_en <= 1'b1;
              r_done  <= 1'b1;
              r_wdata <= w_word;
            end else begin
              r_state <= RD;
              r_rd_en <= 1'b1;
              r_data  <= bus.req_data;
              r_size  <= bus.req_size;
              r_lane  <= bus.req_addr[1:0];
            end
`endif
          end
        end
        RD:   r_state <= WAIT;
        WAIT: begin
          if (bus.mem_rvalid) begin
            r_wdata <= w_word;
            r_state <= WR;
            r_wr_en <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        WR:      r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow: directed table, hand-written reset
// sequence and randomized stores against a byte-level reference model.
module tb_store_narrow;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  store_narrow_if #(.ADDR_W(ADDR_W)) bus ();

  store_narrow #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] old;
    int          lat;
    int          exp_done;
    int          exp_rd;
    int          exp_err;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  typedef struct {
    int          done_cyc;
    int          rd_cnt;
    int          wr_cnt;
    int          err_cnt;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready_before;
    logic        ready_at_done;
  } obs_t;

  // Reference model: byte array of the old word, overwrite the addressed bytes.
  function automatic vec_t model(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input logic [31:0] old, input int lat);
    vec_t v;
    logic [7:0] b[4];
    int lane, nbytes;
    logic legal;
    v.addr = addr; v.data = data; v.size = size; v.old = old; v.lat = lat;
    lane   = int'(addr % 4);
    nbytes = 1 << size;
    legal  = (size == 2'd0) || (size == 2'd1 && lane % 2 == 0) || (size == 2'd2 && lane == 0);
    v.exp_wdata = 32'h0;
    v.exp_be    = 4'h0;
    if (!legal) begin
      v.exp_done = 1; v.exp_rd = 0; v.exp_err = 1;
    end else begin
      v.exp_err = 0;
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
`ifdef STORE_BE_EN
      for (int i = 0; i < 4; i++) b[i] = data[8*(i % nbytes) +: 8];
      for (int j = 0; j < nbytes; j++) v.exp_be[lane + j] = 1'b1;
      v.exp_done = 1; v.exp_rd = 0;
`else
      for (int j = 0; j < nbytes; j++) b[lane + j] = data[8*j +: 8];
      v.exp_done = (nbytes == 4) ? 1 : 2 + lat;
      v.exp_rd   = (nbytes == 4) ? 0 : 1;
`endif
      v.exp_wdata = {b[3], b[2], b[1], b[0]};
    end
    return v;
  endfunction

  task automatic drive_idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_data   = $urandom;
    bus.req_size   = 2'($urandom);
  endtask

  // Issues one request and plays the memory with the given read latency.
  task automatic run_store(input vec_t v, output obs_t o);
    int rd_k = -1;
    o.done_cyc = 0; o.rd_cnt = 0; o.wr_cnt = 0; o.err_cnt = 0;
    o.rd_addr = 32'h0; o.wr_addr = 32'h0; o.wdata = 32'h0; o.be = 4'h0;
    o.ready_at_done = 1'bx;
    @(negedge clk);
    o.ready_before = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_data  = v.data;
    bus.req_size  = v.size;
    @(posedge clk);
    @(negedge clk);
    drive_idle_inputs();
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.mem_rd_en) begin
        o.rd_cnt++;
        o.rd_addr = bus.mem_addr;
        if (rd_k < 0) rd_k = k;
      end
      if (bus.mem_wr_en) begin
        o.wr_cnt++;
        o.wr_addr = bus.mem_addr;
        o.wdata   = bus.mem_wdata;
`ifdef STORE_BE_EN
        o.be      = bus.mem_be;
`endif
      end
      if (bus.misalign_err) o.err_cnt++;
      if (bus.done) begin
        o.done_cyc      = k;
        o.ready_at_done = bus.req_ready;
        break;
      end
      if (rd_k > 0 && k == rd_k + v.lat) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.old;
      end else if (rd_k > 0 && k == rd_k) begin
        bus.mem_rvalid = 1'($urandom);  // stray strobe during RD must be ignored
        bus.mem_rdata  = $urandom;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
    end
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic compare(input string tag, input vec_t v, input obs_t o);
    check({tag, " ready_before"}, 64'(o.ready_before), 64'd1);
    check({tag, " done_cycle"}, 64'(o.done_cyc), 64'(v.exp_done));
    check({tag, " rd_count"}, 64'(o.rd_cnt), 64'(v.exp_rd));
    check({tag, " wr_count"}, 64'(o.wr_cnt), 64'(v.exp_err ? 0 : 1));
    check({tag, " err_count"}, 64'(o.err_cnt), 64'(v.exp_err));
    check({tag, " ready_at_done"}, 64'(o.ready_at_done), 64'd0);
    if (v.exp_err == 0) begin
      check({tag, " wdata"}, 64'(o.wdata), 64'(v.exp_wdata));
      check({tag, " wr_addr"}, 64'(o.wr_addr), 64'(v.addr & 32'hFFFF_FFFC));
`ifdef STORE_BE_EN
      check({tag, " be"}, 64'(o.be), 64'(v.exp_be));
`endif
    end
    if (v.exp_rd != 0) check({tag, " rd_addr"}, 64'(o.rd_addr), 64'(v.addr & 32'hFFFF_FFFC));
  endtask

  vec_t tbl[$];

  initial begin
    obs_t o;
    vec_t v;
    int   busy, wr_seen, done_seen;

    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    drive_idle_inputs();

`ifdef STORE_BE_EN
    tbl.push_back(vec_t'{32'h10, 32'hDEADBEEF, 2'b10, 32'h0, 1, 1, 0, 0, 32'hDEADBEEF, 4'b1111});
    tbl.push_back(vec_t'{32'h22, 32'h0000005A, 2'b00, 32'h0, 1, 1, 0, 0, 32'h5A5A5A5A, 4'b0100});
    tbl.push_back(vec_t'{32'h06, 32'h0000CAFE, 2'b01, 32'h0, 1, 1, 0, 0, 32'hCAFECAFE, 4'b1100});
    tbl.push_back(vec_t'{32'h21, 32'h12345677, 2'b00, 32'h0, 1, 1, 0, 0, 32'h77777777, 4'b0010});
`else
    tbl.push_back(vec_t'{32'h10, 32'hDEADBEEF, 2'b10, 32'h0,        1, 1, 0, 0, 32'hDEADBEEF, 4'hF});
    tbl.push_back(vec_t'{32'h23, 32'h000000AB, 2'b00, 32'h11223344, 3, 5, 1, 0, 32'hAB223344, 4'hF});
    tbl.push_back(vec_t'{32'h06, 32'h0000CAFE, 2'b01, 32'h11223344, 2, 4, 1, 0, 32'hCAFE3344, 4'hF});
    tbl.push_back(vec_t'{32'h20, 32'hFFFFFF77, 2'b00, 32'hAABBCCDD, 1, 3, 1, 0, 32'hAABBCC77, 4'hF});
    tbl.push_back(vec_t'{32'h00, 32'h12345678, 2'b01, 32'hAABBCCDD, 1, 3, 1, 0, 32'hAABB5678, 4'hF});
`endif
    tbl.push_back(vec_t'{32'h05, 32'h0000BEEF, 2'b01, 32'h0, 1, 1, 0, 1, 32'h0, 4'h0});
    tbl.push_back(vec_t'{32'h0A, 32'hDEADBEEF, 2'b10, 32'h0, 1, 1, 0, 1, 32'h0, 4'h0});
    tbl.push_back(vec_t'{32'h00, 32'hDEADBEEF, 2'b11, 32'h0, 1, 1, 0, 1, 32'h0, 4'h0});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 64'(bus.req_ready), 64'd1);
    check("rst rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst err", 64'(bus.misalign_err), 64'd0);
    check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst wdata", 64'(bus.mem_wdata), 64'd0);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      run_store(tbl[i], o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

`ifndef STORE_BE_EN
    // Reset while waiting for read data: the write must never happen.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h31; bus.req_data = 32'h99; bus.req_size = 2'b00;
    @(posedge clk);
    @(negedge clk);
    drive_idle_inputs();
    check("rstwait rd_en", 64'(bus.mem_rd_en), 64'd1);
    @(negedge clk);
    check("rstwait busy", 64'(bus.req_ready), 64'd0);
    rstn = 1'b0;
    #1;
    check("rstwait ready_in_rst", 64'(bus.req_ready), 64'd1);
    check("rstwait addr_in_rst", 64'(bus.mem_addr), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    busy = 0; wr_seen = 0; done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (!bus.req_ready) busy++;
      if (bus.mem_wr_en) wr_seen++;
      if (bus.done) done_seen++;
    end
    check("rstwait no_write", 64'(wr_seen), 64'd0);
    check("rstwait no_done", 64'(done_seen), 64'd0);
    check("rstwait ready_after", 64'(busy), 64'd0);
`endif

    // Randomized stores against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  s;
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      v = model(a, $urandom, s, $urandom, $urandom_range(1, 4));
      run_store(v, o);
      compare($sformatf("rnd%0d", n), v, o);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
